// File: rtl/ps2_host_transmitter_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_host_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5,
        DONE      = 3'd6,
        FAIL      = 3'd7
    } tx_state_t;

    // d0..d7, parity, stop
    localparam int PS2_FRAME_BITS = 10;

endpackage

// File: rtl/ps2_host_transmitter_if.sv
// Command-byte handshake between the host logic and the PS/2 transmitter.
interface ps2_host_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       busy;

    modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_error, busy);
    modport slave  (input tx_data, tx_valid, output tx_ready, tx_done, tx_error, busy);
endinterface

// File: rtl/ps2_host_transmitter_sync.sv
// Two-flop synchronizer for an asynchronous PS/2 pad, plus a one-cycle falling-edge strobe.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic fall
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q;
    assign fall = prev_q & ~sync_q;
endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host transmitter: inhibit, request-to-send, clocked-out frame and device ack check.
module ps2_host_transmitter
    import ps2_host_pkg::*;
#(
    parameter logic [15:0] INHIBIT_CYCLES = 16'd1000,
    parameter logic [7:0]  RTS_CYCLES     = 8'd10,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd150000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    ps2_host_transmitter_if.slave tx,
    input  logic                  device_clock,
    input  logic                  device_data,
    output logic                  device_clock_oe,
    output logic                  device_data_oe
);
    tx_state_t   state_q, state_d;
    logic [9:0]  shift_q, shift_d;
    logic [15:0] inh_q, inh_d;
    logic [7:0]  rts_q, rts_d;
    logic [23:0] to_q, to_d;
    logic [3:0]  bit_q, bit_d;
    logic        clock_oe_q, clock_oe_d;
    logic        data_oe_q, data_oe_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        dmeta_q, dmeta_d;
    logic        dsync_q, dsync_d;

    logic clk_sync, clk_fall;
    logic to_hit;

    ps2_line_sync u_clk_sync (
        .clk   (clock),
        .rst_n (reset_n),
        .din   (device_clock),
        .sync  (clk_sync),
        .fall  (clk_fall)
    );

    always_comb begin
        dmeta_d = device_data;
        dsync_d = dmeta_q;
    end

    assign to_hit = (to_q == TIMEOUT_CYCLES - 24'd1);

    // State register plus datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            inh_q      <= '0;
            rts_q      <= '0;
            to_q       <= '0;
            bit_q      <= '0;
            clock_oe_q <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            dmeta_q    <= 1'b1;
            dsync_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            inh_q      <= inh_d;
            rts_q      <= rts_d;
            to_q       <= to_d;
            bit_q      <= bit_d;
            clock_oe_q <= clock_oe_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            error_q    <= error_d;
            dmeta_q    <= dmeta_d;
            dsync_q    <= dsync_d;
        end
    end

    // Next state and counters.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        inh_d   = inh_q;
        rts_d   = rts_q;
        to_d    = to_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: begin
                if (tx.tx_valid) begin
                    shift_d = {1'b1, ~^tx.tx_data, tx.tx_data};
                    inh_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == INHIBIT_CYCLES - 16'd1) begin
                    rts_d   = '0;
                    state_d = RTS;
                end else begin
                    inh_d = inh_q + 16'd1;
                end
            end
            RTS: begin
                if (rts_q == RTS_CYCLES - 8'd1) begin
                    bit_d   = '0;
                    to_d    = '0;
                    state_d = SEND;
                end else begin
                    rts_d = rts_q + 8'd1;
                end
            end
            SEND: begin
                if (clk_fall) begin
                    shift_d = {1'b1, shift_q[9:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'(PS2_FRAME_BITS - 1)) state_d = ACK;
                end
            end
            ACK: begin
                if (clk_fall) state_d = dsync_q ? FAIL : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (clk_sync && dsync_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Any device-clocked phase aborts if the device goes quiet too long.
        if (state_q inside {SEND, ACK, WAIT_IDLE}) begin
            if (clk_fall)    to_d    = '0;
            else if (to_hit) state_d = FAIL;
            else             to_d    = to_q + 24'd1;
        end
    end

    // Outputs are registered from the next state so they change one cycle after the strobe.
    always_comb begin
        clock_oe_d = (state_d == INHIBIT) || (state_d == RTS);
        done_d     = (state_d == DONE);
        error_d    = (state_d == FAIL);
        data_oe_d  = 1'b0;
        if (state_d == RTS) begin
            data_oe_d = 1'b1;
        end else if (state_d == SEND) begin
            // Start bit stays low until the first device falling edge.
            if (state_q != SEND) data_oe_d = 1'b1;
            else if (clk_fall)   data_oe_d = ~shift_q[0];
            else                 data_oe_d = data_oe_q;
        end
    end

    assign device_clock_oe = clock_oe_q;
    assign device_data_oe  = data_oe_q;
    assign tx.tx_ready     = (state_q == IDLE);
    assign tx.busy         = (state_q != IDLE);
    assign tx.tx_done      = done_q;
    assign tx.tx_error     = error_q;
endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: open-drain pads, a PS/2 device model and a pulse scoreboard.
module tb_ps2_host_transmitter;
    localparam int INH  = 20;
    localparam int RTSC = 4;
    localparam int TO   = 300;
    localparam int HALF = 20;

    logic clock = 1'b0;
    logic reset_n;
    logic dev_clk_drv, dev_data_drv;
    logic pad_clk, pad_data;
    logic device_clock_oe, device_data_oe;

    ps2_host_transmitter_if tx_if ();

    ps2_host_transmitter #(
        .INHIBIT_CYCLES (16'(INH)),
        .RTS_CYCLES     (8'(RTSC)),
        .TIMEOUT_CYCLES (24'(TO))
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .tx              (tx_if),
        .device_clock    (pad_clk),
        .device_data     (pad_data),
        .device_clock_oe (device_clock_oe),
        .device_data_oe  (device_data_oe)
    );

    // Wired-AND open-drain pads with pull-ups.
    assign pad_clk  = ~(device_clock_oe | dev_clk_drv);
    assign pad_data = ~(device_data_oe | dev_data_drv);

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    int n_inh  = 0;
    int n_rts  = 0;
    bit sb_en  = 1'b0;
    logic [1:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Frame as the device must see it: data LSB first, odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d};
    endfunction

    always @(negedge clock) begin
        if (device_clock_oe && !device_data_oe) n_inh++;
        if (device_clock_oe && device_data_oe)  n_rts++;
    end

    // Scoreboard: per-cycle invariants plus expected completion pulses in order.
    always @(negedge clock) begin
        if (sb_en && reset_n) begin
            chk("ready_vs_busy", tx_if.tx_ready, !tx_if.busy);
            if (!tx_if.busy) chk("idle_oe", {device_clock_oe, device_data_oe}, 2'b00);
            if (tx_if.tx_done || tx_if.tx_error) begin
                chk("pulse_oe", {device_clock_oe, device_data_oe}, 2'b00);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {tx_if.tx_error, tx_if.tx_done}, 2'b00);
                end else begin
                    chk("pulse_kind", {tx_if.tx_error, tx_if.tx_done}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(negedge clock);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = d;
        @(negedge clock);
        tx_if.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!tx_if.tx_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("idle_reached", n < 2000, 1);
    endtask

    // Device: wait for request-to-send, clock 11 pulses, sample on rising edges, optional ack.
    task automatic dev_xfer(input bit clk_on, input bit ack, input int rst_fall, output logic [9:0] frame);
        int n = 0;
        frame = '0;
        while (!(tx_if.busy && !device_clock_oe && !pad_data) && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("rts_seen", n < 500, 1);
        if (!clk_on || n >= 500) return;
        repeat (10) @(negedge clock);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) begin
                dev_data_drv = 1'b1;
                repeat (4) @(negedge clock);
            end
            dev_clk_drv = 1'b1;
            if (k == rst_fall) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rst_oe", {device_clock_oe, device_data_oe}, 2'b00);
                chk("rst_busy", tx_if.busy, 1'b0);
                chk("rst_pulses", {tx_if.tx_error, tx_if.tx_done}, 2'b00);
                dev_clk_drv = 1'b0;
                @(negedge clock);
                reset_n = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clock);
            dev_clk_drv = 1'b0;
            if (k <= 10) frame[k-1] = pad_data;
            repeat (HALF) @(negedge clock);
            dev_data_drv = 1'b0;
        end
    endtask

    initial begin
        logic [9:0] fr;
        logic [7:0] vals[3];
        logic [9:0] lits[3];
        int inh0, rts0, n;
        vals = '{8'h00, 8'hFF, 8'h01};
        lits = '{10'h300, 10'h3FF, 10'h201};

        reset_n = 1'b0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data = 8'h00;
        dev_clk_drv = 1'b0;
        dev_data_drv = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_ready", tx_if.tx_ready, 1'b1);
        chk("reset_busy", tx_if.busy, 1'b0);
        chk("reset_oe", {device_clock_oe, device_data_oe}, 2'b00);
        chk("reset_pulses", {tx_if.tx_error, tx_if.tx_done}, 2'b00);
        reset_n = 1'b1;
        @(negedge clock);
        sb_en = 1'b1;

        // 0xED with inhibit / request-to-send durations
        inh0 = n_inh;
        rts0 = n_rts;
        exp_q.push_back(2'b01);
        send(8'hED);
        dev_xfer(1'b1, 1'b1, 0, fr);
        chk("frame_ED", fr, 10'h3ED);
        wait_idle();
        chk("inhibit_cycles", n_inh - inh0, INH);
        chk("rts_cycles", n_rts - rts0, RTSC);
        chk("pulse_ED_seen", exp_q.size(), 0);

        // parity corner bytes
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(2'b01);
            send(vals[i]);
            dev_xfer(1'b1, 1'b1, 0, fr);
            chk("frame_lit", fr, lits[i]);
            chk("frame_model", fr, frame_of(vals[i]));
            wait_idle();
            chk("pulse_seen", exp_q.size(), 0);
        end

        // device never clocks after request-to-send
        exp_q.push_back(2'b10);
        send(8'hF4);
        dev_xfer(1'b0, 1'b0, 0, fr);
        n = 0;
        while (!tx_if.tx_error && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("timeout_cycles", n, TO);
        @(negedge clock);
        chk("timeout_ready", tx_if.tx_ready, 1'b1);
        chk("timeout_oe", {device_clock_oe, device_data_oe}, 2'b00);
        chk("timeout_pulse_seen", exp_q.size(), 0);

        // NACK: data left high on the ack clock
        exp_q.push_back(2'b10);
        send(8'hA5);
        dev_xfer(1'b1, 1'b0, 0, fr);
        chk("frame_A5", fr, frame_of(8'hA5));
        wait_idle();
        chk("nack_pulse_seen", exp_q.size(), 0);

        // tx_valid held through a transfer: second byte waits for IDLE
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        @(negedge clock);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data = 8'hF4;
        @(negedge clock);
        tx_if.tx_data = 8'h55;
        dev_xfer(1'b1, 1'b1, 0, fr);
        chk("frame_F4", fr, frame_of(8'hF4));
        wait_idle();
        @(negedge clock);
        chk("accept_after_idle", tx_if.busy, 1'b1);
        tx_if.tx_valid = 1'b0;
        dev_xfer(1'b1, 1'b1, 0, fr);
        chk("frame_55", fr, frame_of(8'h55));
        wait_idle();
        chk("held_pulses_seen", exp_q.size(), 0);

        // reset at fall #5, then a clean transfer
        send(8'h3C);
        dev_xfer(1'b1, 1'b1, 5, fr);
        @(negedge clock);
        chk("post_reset_ready", tx_if.tx_ready, 1'b1);
        exp_q.push_back(2'b01);
        send(8'hED);
        dev_xfer(1'b1, 1'b1, 0, fr);
        chk("frame_after_reset", fr, 10'h3ED);
        wait_idle();
        repeat (2) @(negedge clock);
        chk("final_pulse_seen", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
